picoblaze_rtc_port_bank: RTL and testbench

- Parametrised PicoBlaze I/O port bank between the KCPSM port bus and the RTC read/write controller.
- Holds N write registers for time/date/timer fields and a one-hot field-select register.
- Provides a registered read mux over coherent snapshots of RTC readback data.
- Generates a level update request with acknowledge handshake, plus a one-cycle timer-modify pulse.

---
 rtl/picoblaze_rtc_port_bank_pkg.sv | 45 ++++
 rtl/picoblaze_rtc_port_bank_onehot_sel_decoder.sv | 18 +
 rtl/picoblaze_rtc_port_bank.sv | 141 ++++++++++++++
 tb/tb_picoblaze_rtc_port_bank.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/picoblaze_rtc_port_bank_pkg.sv
// Shared constants for the PicoBlaze RTC port bank: default port map,
// command codes, timer code, status bit positions and a port-map sanity check.
package rtc_port_pkg;

  localparam int          DEF_N_REGS    = 9;
  localparam logic [7:0]  DEF_SEL_PORT  = 8'h01;
  localparam logic [7:0]  DEF_WR_BASE   = 8'h02;
  localparam logic [7:0]  DEF_CMD_PORT  = 8'h0B;
  localparam logic [7:0]  DEF_STAT_PORT = 8'h0C;
  localparam logic [7:0]  DEF_RD_BASE   = 8'h0D;
  localparam logic [7:0]  DEF_TMR_PORT  = 8'h16;

  localparam logic [7:0]  CMD_GO     = 8'h01;
  localparam logic [7:0]  CMD_SNAP   = 8'h02;
  localparam logic [7:0]  CMD_CANCEL = 8'h00;
  localparam logic [7:0]  TMR_CODE   = 8'h09;

  localparam int STAT_UPD_BIT  = 0;
  localparam int STAT_DONE_BIT = 1;
  localparam int STAT_SNAP_BIT = 2;

  // True when any two port ranges overlap or a field range runs past 8'hFF.
  function automatic bit port_map_bad(input int n,
                                      input logic [7:0] sel, input logic [7:0] wr,
                                      input logic [7:0] cmd, input logic [7:0] stat,
                                      input logic [7:0] rd, input logic [7:0] tmr);
    int lo[6];
    int hi[6];
    bit bad;
    lo[0] = int'(sel);  hi[0] = int'(sel);
    lo[1] = int'(wr);   hi[1] = int'(wr) + n - 1;
    lo[2] = int'(cmd);  hi[2] = int'(cmd);
    lo[3] = int'(stat); hi[3] = int'(stat);
    lo[4] = int'(rd);   hi[4] = int'(rd) + n - 1;
    lo[5] = int'(tmr);  hi[5] = int'(tmr);
    bad = (n < 1) || (n > 256) || (hi[1] > 255) || (hi[4] > 255);
    for (int a = 0; a < 6; a++) begin
      for (int b = a + 1; b < 6; b++) begin
        if ((lo[a] <= hi[b]) && (lo[b] <= hi[a])) bad = 1'b1;
      end
    end
    return bad;
  endfunction

endpackage

// File: rtl/picoblaze_rtc_port_bank_onehot_sel_decoder.sv
// Turns an 8-bit field index into N one-hot bits; indices >= N decode to zero,
// which doubles as the "no field selected" code.
module onehot_sel_decoder #(
  parameter int N = 9
) (
  input  logic [7:0]   sel_i,
  output logic [N-1:0] onehot_o
);

  // Compare the index against every field position.
  always_comb begin
    onehot_o = '0;
    for (int i = 0; i < N; i++) begin
      if (sel_i == 8'(i)) onehot_o[i] = 1'b1;
    end
  end

endmodule

// File: rtl/picoblaze_rtc_port_bank.sv
// PicoBlaze I/O port bank for the RTC: field write registers, one-hot field
// select, update request handshake, timer-modify pulse and a registered read
// mux over a coherent snapshot of the RTC readback.
module picoblaze_rtc_port_bank
  import rtc_port_pkg::*;
#(
  parameter int         N_REGS    = DEF_N_REGS,
  parameter logic [7:0] SEL_PORT  = DEF_SEL_PORT,
  parameter logic [7:0] WR_BASE   = DEF_WR_BASE,
  parameter logic [7:0] CMD_PORT  = DEF_CMD_PORT,
  parameter logic [7:0] STAT_PORT = DEF_STAT_PORT,
  parameter logic [7:0] RD_BASE   = DEF_RD_BASE,
  parameter logic [7:0] TMR_PORT  = DEF_TMR_PORT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            Port_ID,
  input  logic [7:0]            Out_Port,
  input  logic                  write,
  input  logic                  read,
  output logic [7:0]            In_Port,
  output logic [8*N_REGS-1:0]   wr_data,
  input  logic [8*N_REGS-1:0]   rd_data,
  output logic [N_REGS-1:0]     Habilita,
  output logic                  upd_req,
  input  logic                  upd_ack,
  input  logic                  Listo_es,
  output logic                  modifica_timer
);

  localparam bit PORT_MAP_BAD =
    port_map_bad(N_REGS, SEL_PORT, WR_BASE, CMD_PORT, STAT_PORT, RD_BASE, TMR_PORT);

  if (PORT_MAP_BAD) begin : g_bad_port_map
    $error("picoblaze_rtc_port_bank: overlapping or out-of-range port map");
  end

  logic [N_REGS-1:0][7:0] wr_q, wr_d;
  logic [N_REGS-1:0][7:0] snap_q, snap_d;
  logic [7:0]             sel_q, sel_d;
  logic [N_REGS-1:0]      habilita_q, habHot;
  logic                   upd_req_q, upd_req_d;
  logic                   snap_valid_q, snap_valid_d;
  logic                   done_q, done_d;
  logic                   listo_q;
  logic                   tmr_q, tmr_d;
  logic [7:0]             in_port_q, in_port_d;

  logic [7:0]             wrOff, rdOff;
  logic [N_REGS-1:0]      wrHit, rdHit;
  logic                   cmdWrite;

  // Field-relative offsets wrap to large values below the base, so the
  // decoders reject them just like offsets past the last field.
  assign wrOff    = Port_ID - WR_BASE;
  assign rdOff    = Port_ID - RD_BASE;
  assign cmdWrite = write && (Port_ID == CMD_PORT);

  onehot_sel_decoder #(.N(N_REGS)) u_wrDec  (.sel_i(wrOff), .onehot_o(wrHit));
  onehot_sel_decoder #(.N(N_REGS)) u_rdDec  (.sel_i(rdOff), .onehot_o(rdHit));
  onehot_sel_decoder #(.N(N_REGS)) u_habDec (.sel_i(sel_d), .onehot_o(habHot));

  // Next-state for every write-side register, handshake and sticky status.
  always_comb begin
    wr_d         = wr_q;
    sel_d        = sel_q;
    snap_d       = snap_q;
    snap_valid_d = snap_valid_q;
    upd_req_d    = upd_req_q;
    done_d       = done_q;
    tmr_d        = write && (Port_ID == TMR_PORT) && (Out_Port == TMR_CODE);

    for (int i = 0; i < N_REGS; i++) begin
      if (write && wrHit[i]) wr_d[i] = Out_Port;
    end
    if (write && (Port_ID == SEL_PORT)) sel_d = Out_Port;

    if (upd_req_q && upd_ack) upd_req_d = 1'b0;
    if (cmdWrite && (Out_Port == CMD_GO)) begin
      upd_req_d    = 1'b1;
      snap_valid_d = 1'b0;
    end
    if (cmdWrite && (Out_Port == CMD_CANCEL)) upd_req_d = 1'b0;
    if (cmdWrite && (Out_Port == CMD_SNAP)) begin
      snap_d       = rd_data;
      snap_valid_d = 1'b1;
    end

    if (Listo_es && !listo_q)                done_d = 1'b1;
    else if (read && (Port_ID == STAT_PORT)) done_d = 1'b0;
  end

  // Read mux over the current register state; port ranges never overlap.
  always_comb begin
    in_port_d = 8'h00;
    if (Port_ID == SEL_PORT) in_port_d = sel_q;
    if (Port_ID == STAT_PORT) begin
      in_port_d[STAT_UPD_BIT]  = upd_req_q;
      in_port_d[STAT_DONE_BIT] = done_q;
      in_port_d[STAT_SNAP_BIT] = snap_valid_q;
    end
    for (int i = 0; i < N_REGS; i++) begin
      if (wrHit[i]) in_port_d = in_port_d | wr_q[i];
      if (rdHit[i]) in_port_d = in_port_d | snap_q[i];
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q         <= '0;
      snap_q       <= '0;
      sel_q        <= 8'h00;
      habilita_q   <= N_REGS'(1);
      upd_req_q    <= 1'b0;
      snap_valid_q <= 1'b0;
      done_q       <= 1'b0;
      listo_q      <= 1'b0;
      tmr_q        <= 1'b0;
      in_port_q    <= 8'h00;
    end else begin
      wr_q         <= wr_d;
      snap_q       <= snap_d;
      sel_q        <= sel_d;
      habilita_q   <= habHot;
      upd_req_q    <= upd_req_d;
      snap_valid_q <= snap_valid_d;
      done_q       <= done_d;
      listo_q      <= Listo_es;
      tmr_q        <= tmr_d;
      in_port_q    <= in_port_d;
    end
  end

  assign In_Port        = in_port_q;
  assign wr_data        = wr_q;
  assign Habilita       = habilita_q;
  assign upd_req        = upd_req_q;
  assign modifica_timer = tmr_q;

endmodule

// File: tb/tb_picoblaze_rtc_port_bank.sv
// Directed self-checking bench for picoblaze_rtc_port_bank with the default port map.
module tb_picoblaze_rtc_port_bank;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  Port_ID = 8'h00;
  logic [7:0]  Out_Port = 8'h00;
  logic        write = 1'b0;
  logic        read = 1'b0;
  logic [7:0]  In_Port;
  logic [71:0] wr_data;
  logic [71:0] rd_data = 72'h0;
  logic [8:0]  Habilita;
  logic        upd_req;
  logic        upd_ack = 1'b0;
  logic        Listo_es = 1'b0;
  logic        modifica_timer;

  int checks = 0;
  int errors = 0;

  picoblaze_rtc_port_bank dut (
    .clk(clk), .reset(reset), .Port_ID(Port_ID), .Out_Port(Out_Port),
    .write(write), .read(read), .In_Port(In_Port), .wr_data(wr_data),
    .rd_data(rd_data), .Habilita(Habilita), .upd_req(upd_req),
    .upd_ack(upd_ack), .Listo_es(Listo_es), .modifica_timer(modifica_timer)
  );

  always #5 clk = ~clk;

  // Advance one clock and settle just after the active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pbWrite(input logic [7:0] port, input logic [7:0] data);
    Port_ID  = port;
    Out_Port = data;
    write    = 1'b1;
    tick();
    write    = 1'b0;
    Port_ID  = 8'hFF;
  endtask

  task automatic pbRead(input logic [7:0] port, output logic [7:0] data);
    Port_ID = port;
    read    = 1'b1;
    tick();
    read    = 1'b0;
    Port_ID = 8'hFF;
    data    = In_Port;
  endtask

  task automatic test_reset();
    logic [7:0] d;
    rd_data = 72'hA5A5_A5A5_A5A5_A5A5_A5;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    checks++;
    if (Habilita !== 9'b000000001) begin
      errors++; $display("[TB] FAIL reset_habilita got %b want %b", Habilita, 9'b000000001);
    end
    checks++;
    if (upd_req !== 1'b0 || modifica_timer !== 1'b0 || wr_data !== 72'h0 || In_Port !== 8'h00) begin
      errors++;
      $display("[TB] FAIL reset_outputs got req=%b tmr=%b wr=%h in=%h want 0", upd_req, modifica_timer, wr_data, In_Port);
    end
    pbRead(8'h01, d);
    checks++;
    if (d !== 8'h00) begin errors++; $display("[TB] FAIL reset_sel_read got %h want 00", d); end
    pbRead(8'h0C, d);
    checks++;
    if (d !== 8'h00) begin errors++; $display("[TB] FAIL reset_stat_read got %h want 00", d); end
    pbRead(8'h0D, d);
    checks++;
    if (d !== 8'h00) begin errors++; $display("[TB] FAIL reset_rd0_read got %h want 00", d); end
    rd_data = 72'h0;
  endtask

  task automatic test_write_select();
    logic [7:0] d;
    pbWrite(8'h04, 8'h24);
    checks++;
    if (wr_data !== (72'h24 << 16)) begin
      errors++; $display("[TB] FAIL wr_field2 got %h want %h", wr_data, 72'h24 << 16);
    end
    pbWrite(8'h0A, 8'h5A);
    checks++;
    if (wr_data !== ((72'h5A << 64) | (72'h24 << 16))) begin
      errors++; $display("[TB] FAIL wr_field8 got %h want %h", wr_data, (72'h5A << 64) | (72'h24 << 16));
    end
    pbRead(8'h04, d);
    checks++;
    if (d !== 8'h24) begin errors++; $display("[TB] FAIL wr_readback got %h want 24", d); end
    pbWrite(8'h01, 8'h07);
    checks++;
    if (Habilita !== 9'b010000000) begin
      errors++; $display("[TB] FAIL habilita_sel7 got %b want %b", Habilita, 9'b010000000);
    end
    pbWrite(8'h01, 8'h08);
    checks++;
    if (Habilita !== 9'b100000000) begin
      errors++; $display("[TB] FAIL habilita_sel8 got %b want %b", Habilita, 9'b100000000);
    end
    pbWrite(8'h01, 8'h09);
    checks++;
    if (Habilita !== 9'b000000000) begin
      errors++; $display("[TB] FAIL habilita_sel9 got %b want 0", Habilita);
    end
    pbWrite(8'h20, 8'hFF);
    checks++;
    if (wr_data !== ((72'h5A << 64) | (72'h24 << 16)) || Habilita !== 9'b0) begin
      errors++; $display("[TB] FAIL unmapped_write got wr=%h hab=%b want unchanged", wr_data, Habilita);
    end
    pbRead(8'h01, d);
    checks++;
    if (d !== 8'h09) begin errors++; $display("[TB] FAIL sel_readback got %h want 09", d); end
  endtask

  task automatic test_handshake();
    logic [7:0] d;
    pbWrite(8'h0B, 8'h01);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (upd_req !== 1'b1) begin
        errors++; $display("[TB] FAIL req_hold cycle %0d got %b want 1", i, upd_req);
      end
      tick();
    end
    upd_ack = 1'b1;
    tick();
    upd_ack = 1'b0;
    checks++;
    if (upd_req !== 1'b0) begin errors++; $display("[TB] FAIL req_after_ack got %b want 0", upd_req); end
    upd_ack = 1'b1;
    tick();
    upd_ack = 1'b0;
    checks++;
    if (upd_req !== 1'b0) begin errors++; $display("[TB] FAIL ack_while_idle got %b want 0", upd_req); end
    pbWrite(8'h0B, 8'h01);
    upd_ack = 1'b1;
    pbWrite(8'h0B, 8'h01);
    upd_ack = 1'b0;
    checks++;
    if (upd_req !== 1'b1) begin errors++; $display("[TB] FAIL go_with_ack got %b want 1", upd_req); end
    pbRead(8'h0C, d);
    checks++;
    if (d !== 8'h01) begin errors++; $display("[TB] FAIL stat_pending got %h want 01", d); end
    pbWrite(8'h0B, 8'h00);
    checks++;
    if (upd_req !== 1'b0) begin errors++; $display("[TB] FAIL cancel got %b want 0", upd_req); end
  endtask

  task automatic test_snapshot();
    logic [7:0] d;
    rd_data = 72'h0;
    rd_data[47:40] = 8'h59;
    rd_data[71:64] = 8'hA8;
    pbWrite(8'h0B, 8'h02);
    rd_data = 72'h0;
    pbRead(8'h12, d);
    checks++;
    if (d !== 8'h59) begin errors++; $display("[TB] FAIL snap_field5 got %h want 59", d); end
    pbRead(8'h15, d);
    checks++;
    if (d !== 8'hA8) begin errors++; $display("[TB] FAIL snap_field8 got %h want a8", d); end
    pbRead(8'h0C, d);
    checks++;
    if (d !== 8'h04) begin errors++; $display("[TB] FAIL stat_snap_valid got %h want 04", d); end
    pbWrite(8'h0B, 8'h01);
    pbRead(8'h0C, d);
    checks++;
    if (d !== 8'h01) begin errors++; $display("[TB] FAIL stat_go_clears_snap got %h want 01", d); end
    pbWrite(8'h0B, 8'h00);
  endtask

  task automatic test_timer();
    pbWrite(8'h16, 8'h09);
    checks++;
    if (modifica_timer !== 1'b1) begin errors++; $display("[TB] FAIL tmr_pulse got %b want 1", modifica_timer); end
    tick();
    checks++;
    if (modifica_timer !== 1'b0) begin errors++; $display("[TB] FAIL tmr_pulse_end got %b want 0", modifica_timer); end
    pbWrite(8'h16, 8'h08);
    checks++;
    if (modifica_timer !== 1'b0) begin errors++; $display("[TB] FAIL tmr_wrong_code got %b want 0", modifica_timer); end
    pbWrite(8'h15, 8'h09);
    checks++;
    if (modifica_timer !== 1'b0) begin errors++; $display("[TB] FAIL tmr_wrong_port got %b want 0", modifica_timer); end
  endtask

  task automatic test_sticky();
    logic [7:0] d;
    Listo_es = 1'b1;
    tick();
    Listo_es = 1'b0;
    tick();
    pbRead(8'h0C, d);
    checks++;
    if (d !== 8'h02) begin errors++; $display("[TB] FAIL done_set got %h want 02", d); end
    pbRead(8'h0C, d);
    checks++;
    if (d !== 8'h00) begin errors++; $display("[TB] FAIL done_cleared got %h want 00", d); end
    Listo_es = 1'b1;
    pbRead(8'h0C, d);
    checks++;
    if (d !== 8'h00) begin errors++; $display("[TB] FAIL done_coincide_old got %h want 00", d); end
    pbRead(8'h0C, d);
    checks++;
    if (d !== 8'h02) begin errors++; $display("[TB] FAIL done_set_wins got %h want 02", d); end
    pbRead(8'h0C, d);
    checks++;
    if (d !== 8'h00) begin errors++; $display("[TB] FAIL done_level_no_reset got %h want 00", d); end
    Listo_es = 1'b0;
  endtask

  task automatic test_reset_pending();
    pbWrite(8'h0B, 8'h01);
    checks++;
    if (upd_req !== 1'b1) begin errors++; $display("[TB] FAIL req_before_reset got %b want 1", upd_req); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (upd_req !== 1'b0 || Habilita !== 9'b000000001 || wr_data !== 72'h0) begin
      errors++;
      $display("[TB] FAIL reset_pending got req=%b hab=%b wr=%h want 0/000000001/0", upd_req, Habilita, wr_data);
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_write_select();
    test_handshake();
    test_snapshot();
    test_timer();
    test_sticky();
    test_reset_pending();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired got timeout want finish");
    $fatal(1, "[TB] watchdog");
  end

endmodule
